timestamp_capture_mc: RTL

TIMESTAMP_CAPTURE_MC -- requirements
Module: timestamp_capture_mc

---
 rtl/timestamp_capture_pkg.sv | 42 ++++
 rtl/timestamp_fifo_ram.sv | 22 ++
 rtl/timestamp_capture_mc.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/timestamp_capture_pkg.sv
// Shared constants for the timestamp capture peripheral: register map,
// CONTROL/STATUS bit positions, FIFO entry layout and capture FSM states.
package timestamp_capture_pkg;

  localparam logic [2:0] ADR_LPT_LO  = 3'd0;
  localparam logic [2:0] ADR_LPT_HI  = 3'd1;
  localparam logic [2:0] ADR_HPT_LO  = 3'd2;
  localparam logic [2:0] ADR_HPT_HI  = 3'd3;
  localparam logic [2:0] ADR_TSR     = 3'd4;
  localparam logic [2:0] ADR_RISE_EN = 3'd4;
  localparam logic [2:0] ADR_CONTROL = 3'd5;
  localparam logic [2:0] ADR_STATUS  = 3'd6;
  localparam logic [2:0] ADR_FALL_EN = 3'd7;

  // Word slots inside one FIFO entry; the read address bits [2:1] pick the slot.
  localparam logic [1:0] WORD_LPT = 2'd0;
  localparam logic [1:0] WORD_HPT = 2'd1;
  localparam logic [1:0] WORD_TSR = 2'd2;

  localparam int unsigned CTL_CLEAR   = 17;
  localparam int unsigned CTL_POP     = 16;
  localparam int unsigned STC_IRQ_EN  = 0;
  localparam int unsigned STC_OVF_CLR = 1;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_IRQ_EN    = 2;
  localparam int unsigned ST_OVF_LSB   = 3;
  localparam int unsigned ST_FILL_LSB  = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_W_LPT,
    S_W_HPT,
    S_W_TSR
  } cap_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/timestamp_fifo_ram.sv
// Simple dual-port RAM holding the capture FIFO entries (one write port,
// one synchronous read port).
module timestamp_fifo_ram #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 36
) (
  input  logic          clk_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);

  logic [DW-1:0] mem_q [0:(1 << AW)-1];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/timestamp_capture_mc.sv
// Multi-channel timestamp capture: edge/software events latch the time bases
// into a FIFO of {LPT, HPT, TSR} entries readable over the peripheral bus.
module timestamp_capture_mc
  import timestamp_capture_pkg::*;
#(
  parameter logic [9:0]  BASE_ADR              = 10'h1A0,
  parameter int unsigned SOURCES               = 4,
  parameter int unsigned PIN_SOURCES           = 4,
  parameter int unsigned FIFO_DEPTH_LOG2       = 5,
  parameter logic [15:0] INVERTED_SOURCES_MASK = '0
) (
  input  logic                   clk_peri,
  input  logic                   reset,
  input  logic                   access_peri,
  input  logic                   wr_peri,
  input  logic [9:0]             addr_peri,
  input  logic [17:0]            do_peri,
  output logic [17:0]            di_peri,
  input  logic [SOURCES-1:0]     internal_source,
  input  logic [PIN_SOURCES-1:0] pin_source,
  input  logic [35:0]            lpt_counter,
  input  logic [35:0]            hpt_counter,
  output logic                   irq
);

  localparam int unsigned SUM = SOURCES + PIN_SOURCES;
  localparam int unsigned L   = FIFO_DEPTH_LOG2;
  localparam int unsigned PW  = FIFO_DEPTH_LOG2 + 1;

  if (SUM < 1 || SUM > 16) begin : g_bad_sum
    $error("timestamp_capture_mc: SOURCES+PIN_SOURCES must be 1..16");
  end
  if (FIFO_DEPTH_LOG2 < 2 || FIFO_DEPTH_LOG2 > 6) begin : g_bad_depth
    $error("timestamp_capture_mc: FIFO_DEPTH_LOG2 must be 2..6");
  end
  if (BASE_ADR[2:0] != 3'd0) begin : g_bad_base
    $error("timestamp_capture_mc: BASE_ADR must be divisible by 8");
  end

  localparam logic [SUM-1:0] INV_MASK = INVERTED_SOURCES_MASK[SUM-1:0];

  logic [PIN_SOURCES-1:0] pin_meta_q, pin_sync_q;
  logic [SUM-1:0]   src, edge_vec, last_q, last_d, rise_en_q, fall_en_q;
  logic [15:0]      edge_ext;
  logic [PW-1:0]    wp_q, wp_d, rp_q, fill_raw;
  cap_state_e       state_q, state_d;
  logic [35:0]      hpt_q, hpt_d;
  logic [17:0]      tsr_q, tsr_d, ev_tsr;
  logic             ovf_flag_q, ovf_flag_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;
  logic             sw_req_q, sw_req_d;
  logic [15:0]      sw_tag_q, sw_tag_d;
  logic             irq_en_q, irq_q;
  logic             rd_q;
  logic [2:0]       rd_adr_q;
  logic [17:0]      status, status_q;
  logic             sel, wr_stb, ctl_wr, stc_wr, sw_new, sw_take, ev_hit;
  logic             empty, full;
  logic             ram_we;
  logic [1:0]       ram_wword;
  logic [35:0]      ram_wdata, ram_rdata;

  assign sel    = access_peri & (addr_peri[9:3] == BASE_ADR[9:3]);
  assign wr_stb = sel & wr_peri;
  assign ctl_wr = wr_stb & (addr_peri[2:0] == ADR_CONTROL);
  assign stc_wr = wr_stb & (addr_peri[2:0] == ADR_STATUS);
  assign sw_new = ctl_wr & (do_peri[15:0] != 16'h0000);

  assign src      = {pin_sync_q, internal_source} ^ INV_MASK;
  assign edge_vec = (src & ~last_q & rise_en_q) | (~src & last_q & fall_en_q);

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[L] != rp_q[L]) && (wp_q[L-1:0] == rp_q[L-1:0]);
  assign fill_raw = wp_q - rp_q;

  // A CONTROL write landing in IDLE is taken at once so it still wins over a
  // hardware edge seen in the same cycle.
  assign sw_take = sw_req_q | sw_new;
  assign ev_hit  = sw_take | (edge_vec != '0);

  always_comb begin
    edge_ext = '0;
    edge_ext[SUM-1:0] = edge_vec;
    if (sw_take) ev_tsr = {1'b1, ovf_flag_q, sw_req_q ? sw_tag_q : do_peri[15:0]};
    else         ev_tsr = {1'b0, ovf_flag_q, edge_ext};
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hpt_d      = hpt_q;
    tsr_d      = tsr_q;
    ovf_flag_d = ovf_flag_q;
    ovf_cnt_d  = ovf_cnt_q;
    wp_d       = wp_q;
    sw_req_d   = sw_req_q;
    sw_tag_d   = sw_tag_q;
    ram_we     = 1'b0;
    ram_wword  = WORD_LPT;
    ram_wdata  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!sw_take) last_d = src;
        if (sw_req_q) sw_req_d = 1'b0;
        if (ev_hit) begin
          if (full) begin
            ovf_cnt_d  = sat_inc8(ovf_cnt_q);
            ovf_flag_d = 1'b1;
          end else begin
            hpt_d      = hpt_counter;
            tsr_d      = ev_tsr;
            ovf_flag_d = 1'b0;
            state_d    = S_W_LPT;
          end
        end
      end
      S_W_LPT: begin
        ram_we    = 1'b1;
        ram_wword = WORD_LPT;
        ram_wdata = lpt_counter;
        state_d   = S_W_HPT;
      end
      S_W_HPT: begin
        ram_we    = 1'b1;
        ram_wword = WORD_HPT;
        ram_wdata = hpt_q;
        state_d   = S_W_TSR;
      end
      S_W_TSR: begin
        ram_we    = 1'b1;
        ram_wword = WORD_TSR;
        ram_wdata = {18'h0, tsr_q};
        wp_d      = wp_q + PW'(1);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (sw_new && (sw_req_q || state_q != S_IDLE)) begin
      sw_req_d = 1'b1;
      sw_tag_d = do_peri[15:0];
    end
    if (stc_wr && do_peri[STC_OVF_CLR]) ovf_cnt_d = '0;
  end

  always_comb begin
    status = '0;
    status[ST_NOT_EMPTY]        = ~empty;
    status[ST_FULL]             = full;
    status[ST_IRQ_EN]           = irq_en_q;
    status[ST_OVF_LSB +: 8]     = ovf_cnt_q;
    status[ST_FILL_LSB +: 7]    = 7'(fill_raw);
  end

  always_ff @(posedge clk_peri) begin
    pin_meta_q <= pin_source;
    pin_sync_q <= pin_meta_q;
  end

  always_ff @(posedge clk_peri) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      last_q     <= '1;
      rise_en_q  <= '1;
      fall_en_q  <= '0;
      hpt_q      <= '0;
      tsr_q      <= '0;
      ovf_flag_q <= 1'b0;
      ovf_cnt_q  <= '0;
      sw_req_q   <= 1'b0;
      sw_tag_q   <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      rd_q       <= 1'b0;
      rd_adr_q   <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      last_q     <= last_d;
      hpt_q      <= hpt_d;
      tsr_q      <= tsr_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_cnt_q  <= ovf_cnt_d;
      sw_req_q   <= sw_req_d;
      sw_tag_q   <= sw_tag_d;
      irq_q      <= irq_en_q & ~empty;
      rd_q       <= sel & ~wr_peri;
      rd_adr_q   <= addr_peri[2:0];
      status_q   <= status;
      if (wr_stb && addr_peri[2:0] == ADR_RISE_EN) rise_en_q <= do_peri[SUM-1:0];
      if (wr_stb && addr_peri[2:0] == ADR_FALL_EN) fall_en_q <= do_peri[SUM-1:0];
      if (stc_wr) irq_en_q <= do_peri[STC_IRQ_EN];
      // Clear snaps to the committed write pointer, so an entry already in
      // flight still lands after the clear.
      if (ctl_wr && do_peri[CTL_CLEAR])                rp_q <= wp_q;
      else if (ctl_wr && do_peri[CTL_POP] && !empty)   rp_q <= rp_q + PW'(1);
    end
  end

  timestamp_fifo_ram #(
    .AW (L + 2),
    .DW (36)
  ) u_ram (
    .clk_i     (clk_peri),
    .rd_addr_i ({rp_q[L-1:0], addr_peri[2:1]}),
    .rd_data_o (ram_rdata),
    .wr_en_i   (ram_we),
    .wr_addr_i ({wp_q[L-1:0], ram_wword}),
    .wr_data_i (ram_wdata)
  );

  always_comb begin
    di_peri = '0;
    if (rd_q) begin
      unique case (rd_adr_q)
        ADR_LPT_LO, ADR_HPT_LO, ADR_TSR: di_peri = ram_rdata[17:0];
        ADR_LPT_HI, ADR_HPT_HI:          di_peri = ram_rdata[35:18];
        ADR_STATUS:                      di_peri = status_q;
        default:                         di_peri = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule
